// File: rtl/wb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_ram
// Brief    : Wishbone B3 SRAM slave with first-access wait states, registered
//            read data and CTI/BTE incrementing bursts (linear, wrap 4/8/16).
//            Define WB_BURST_RAM_RANGE_CHECK_EN to error out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_ram #(
    parameter int    DW          = 32,
    parameter int    AW          = 32,
    parameter int    DEPTH       = 4096,
    parameter int    WAIT_STATES = 0,
    parameter string MEMFILE     = ""
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int       c_NB  = DW / 8;
    localparam int       c_OFF = $clog2(c_NB);
    localparam int       c_IW  = $clog2(DEPTH);
    localparam int       c_WW  = AW - c_OFF;
    localparam bit [2:0] c_WS  = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACK   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    logic [DW-1:0]   r_mem [DEPTH];
    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [c_WW-1:0] r_addr;
    logic            r_ack;
    logic            r_err;
    logic [DW-1:0]   r_dat;

    logic            w_cs;
    logic            w_wr;
    logic            w_rsp;
    logic            w_rsp_oor;
    logic [c_WW-1:0] w_word_in;
    logic [c_WW-1:0] w_mask;
    logic [c_WW-1:0] w_next;
    logic [c_WW-1:0] w_rsp_addr;
    logic [c_IW-1:0] w_rd_idx;
    logic [DW-1:0]   w_rd_data;
    logic            w_unused;

    assign w_cs      = wb_cyc_i & wb_stb_i;
    assign w_word_in = wb_adr_i[AW-1:c_OFF];
    assign w_wr      = r_ack & w_cs & wb_we_i;

    // Linear bursts use an all-ones mask so the whole word address increments.
    always_comb begin
        w_mask = '1;
        case (wb_bte_i)
            2'b01:   w_mask = c_WW'(3);
            2'b10:   w_mask = c_WW'(7);
            2'b11:   w_mask = c_WW'(15);
            default: w_mask = '1;
        endcase
    end

    assign w_next = (r_addr & ~w_mask) | ((r_addr + c_WW'(1)) & w_mask);

    // w_rsp: the next cycle carries a response for w_rsp_addr.
    always_comb begin
        w_rsp      = 1'b0;
        w_rsp_addr = r_addr;
        case (r_state)
            S_IDLE: begin
                w_rsp_addr = w_word_in;
                w_rsp      = w_cs && (WAIT_STATES == 0);
            end
            S_WAIT: begin
                w_rsp_addr = r_addr;
                w_rsp      = w_cs && (r_cnt == 3'd1);
            end
            default: begin
                w_rsp_addr = w_next;
                w_rsp      = w_cs && !r_err && (wb_cti_i == 3'b010);
            end
        endcase
    end

`ifdef WB_BURST_RAM_RANGE_CHECK_EN
    assign w_rsp_oor = (w_rsp_addr >> c_IW) != '0;
`else
    assign w_rsp_oor = 1'b0;
`endif

    assign w_rd_idx = w_rsp_addr[c_IW-1:0];

    // Same-edge write to the word being fetched is forwarded lane by lane.
    for (genvar j = 0; j < c_NB; j++) begin : g_lane
        assign w_rd_data[8*j +: 8] =
            (w_wr && wb_sel_i[j] && (r_addr[c_IW-1:0] == w_rd_idx)) ?
            wb_dat_i[8*j +: 8] : r_mem[w_rd_idx][8*j +: 8];
    end

    always_ff @(posedge wb_clk) begin
        if (w_wr) begin
            for (int j = 0; j < c_NB; j++) begin
                if (wb_sel_i[j]) r_mem[r_addr[c_IW-1:0]][8*j +: 8] <= wb_dat_i[8*j +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_rsp) begin
                r_ack <= !w_rsp_oor;
                r_err <= w_rsp_oor;
                r_dat <= w_rsp_oor ? '0 : w_rd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cs) begin
                        r_addr  <= w_word_in;
                        r_cnt   <= c_WS;
                        r_state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_cs) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) r_state <= S_ACK;
                    end
                end
                default: begin
                    if (w_rsp) begin
                        r_addr  <= w_next;
                        r_state <= S_BURST;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Gating with cyc&stb keeps a master-wait or aborted cycle from seeing a stale ack.
    assign wb_ack_o = r_ack & w_cs;
    assign wb_err_o = r_err & w_cs;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = r_dat;

    assign w_unused = &{1'b0, wb_adr_i, r_addr, w_next, w_rsp_addr};

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_ram
// Brief    : Self-checking bench for wb_burst_ram; two instances (0 and 3 wait
//            states) against a word-array reference model with random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_ram;

    localparam int c_DEPTH = 4096;
    localparam int c_WS0   = 0;
    localparam int c_WS1   = 3;
`ifdef WB_BURST_RAM_RANGE_CHECK_EN
    localparam bit c_RC = 1'b1;
`else
    localparam bit c_RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r_rst_n;
    logic        r_dsel;
    logic        r_cyc, r_stb, r_we;
    logic [31:0] r_adr, r_dat;
    logic [3:0]  r_sel;
    logic [2:0]  r_cti;
    logic [1:0]  r_bte;

    logic [31:0] w_dat0, w_dat1, w_dat;
    logic        w_ack0, w_ack1, w_ack, w_err0, w_err1, w_err, w_rty0, w_rty1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl  [2][c_DEPTH];
    bit          mval [2][c_DEPTH];
    logic [31:0] t_dat [16];
    logic [3:0]  t_sel [16];
    logic [31:0] t_rd  [16];
    bit          t_err;

    always #5 clk = ~clk;

    wb_burst_ram #(.DW(32), .AW(32), .DEPTH(c_DEPTH), .WAIT_STATES(c_WS0), .MEMFILE("")) u_dut0 (
        .wb_clk(clk), .wb_rst_n(r_rst_n), .wb_adr_i(r_adr), .wb_dat_i(r_dat),
        .wb_sel_i(r_sel), .wb_we_i(r_we), .wb_cyc_i(r_cyc & (r_dsel == 1'b0)),
        .wb_stb_i(r_stb), .wb_cti_i(r_cti), .wb_bte_i(r_bte),
        .wb_dat_o(w_dat0), .wb_ack_o(w_ack0), .wb_err_o(w_err0), .wb_rty_o(w_rty0)
    );

    wb_burst_ram #(.DW(32), .AW(32), .DEPTH(c_DEPTH), .WAIT_STATES(c_WS1), .MEMFILE("")) u_dut1 (
        .wb_clk(clk), .wb_rst_n(r_rst_n), .wb_adr_i(r_adr), .wb_dat_i(r_dat),
        .wb_sel_i(r_sel), .wb_we_i(r_we), .wb_cyc_i(r_cyc & (r_dsel == 1'b1)),
        .wb_stb_i(r_stb), .wb_cti_i(r_cti), .wb_bte_i(r_bte),
        .wb_dat_o(w_dat1), .wb_ack_o(w_ack1), .wb_err_o(w_err1), .wb_rty_o(w_rty1)
    );

    assign w_dat = r_dsel ? w_dat1 : w_dat0;
    assign w_ack = r_dsel ? w_ack1 : w_ack0;
    assign w_err = r_dsel ? w_err1 : w_err0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int beat_addr(input int start, input int base, input int len, input int beat);
        return (len == 0) ? start + beat : base + ((start - base + beat) % len);
    endfunction

    task automatic drive(input int addr, input int beat, input int n, input bit classic, input bit open_end);
        r_adr = 32'(addr * 4);
        r_dat = t_dat[beat];
        r_sel = t_sel[beat];
        r_cti = classic ? 3'b000 : ((beat == n - 1) && !open_end) ? 3'b111 : 3'b010;
    endtask

    // One master transaction: n beats from word 'start', checked beat by beat.
    task automatic xfer(input bit d, input int start, input int n, input int bt,
                        input bit wr, input bit classic, input bit open_end);
        int          len, base, addr, idx, waited, beat, ws;
        bit          a, e, exp_e, stop;
        logic [31:0] rd, m;
        len    = (bt == 1) ? 4 : (bt == 2) ? 8 : (bt == 3) ? 16 : 0;
        base   = (len == 0) ? start : start - (start % len);
        ws     = d ? c_WS1 : c_WS0;
        t_err  = 1'b0;
        beat   = 0;
        waited = 0;
        stop   = 1'b0;
        @(posedge clk); #1;
        r_dsel = d; r_cyc = 1'b1; r_stb = 1'b1; r_we = wr; r_bte = 2'(bt);
        addr = beat_addr(start, base, len, 0);
        drive(addr, 0, n, classic, open_end);
        while (beat < n && !stop) begin
            @(negedge clk);
            a = w_ack; e = w_err; rd = w_dat;
            if (a || e) begin
                exp_e = c_RC && (addr >= c_DEPTH);
                idx   = addr % c_DEPTH;
                check("latency", 64'(waited), (beat == 0) ? 64'(ws + 1) : 64'd0);
                check("ack", 64'(a), 64'(!exp_e));
                check("err", 64'(e), 64'(exp_e));
                if (exp_e) check("err_dat", 64'(rd), 64'd0);
                else if (!wr && mval[d][idx]) check("rd_dat", 64'(rd), 64'(mdl[d][idx]));
                t_rd[beat] = rd;
                if (e) begin
                    t_err = 1'b1;
                    stop  = 1'b1;
                end
                if (wr && !exp_e) begin
                    m = mdl[d][idx];
                    for (int b = 0; b < 4; b++)
                        if (t_sel[beat][b]) m[8*b +: 8] = t_dat[beat][8*b +: 8];
                    mdl[d][idx] = m;
                    if (t_sel[beat] == 4'hF) mval[d][idx] = 1'b1;
                end
                beat++;
                waited = 0;
                @(posedge clk); #1;
                if (beat < n && !stop) begin
                    addr = beat_addr(start, base, len, beat);
                    drive(addr, beat, n, classic, open_end);
                end
            end else begin
                waited++;
                if (waited > 12) begin
                    check("ack_timeout", 64'(waited), 64'(ws + 1));
                    stop = 1'b1;
                    @(posedge clk); #1;
                end
            end
        end
        if (open_end) begin
            r_stb = 1'b0;
            @(negedge clk);
            check("ack_after_stb_drop", 64'(w_ack), 64'd0);
        end else begin
            @(negedge clk);
            check("ack_low_after_end", 64'(w_ack), 64'd0);
            check("err_low_after_end", 64'(w_err), 64'd0);
        end
        @(posedge clk); #1;
        r_cyc = 1'b0; r_stb = 1'b0; r_we = 1'b0; r_cti = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w [4];
        int          len, bt, n;
        r_rst_n = 1'b1; r_dsel = 1'b0; r_cyc = 1'b0; r_stb = 1'b0; r_we = 1'b0;
        r_adr = '0; r_dat = '0; r_sel = '0; r_cti = '0; r_bte = '0;
        for (int i = 0; i < 16; i++) begin
            t_dat[i] = '0;
            t_sel[i] = 4'hF;
            t_rd[i]  = '0;
        end
        #2 r_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", 64'(w_ack0), 64'd0);
        check("rst_err0", 64'(w_err0), 64'd0);
        check("rst_rty0", 64'(w_rty0), 64'd0);
        check("rst_dat0", 64'(w_dat0), 64'd0);
        check("rst_ack1", 64'(w_ack1), 64'd0);
        check("rst_dat1", 64'(w_dat1), 64'd0);
        r_rst_n = 1'b1;

        // classic write/read, zero wait states
        t_dat[0] = 32'hDEADBEEF; t_sel[0] = 4'hF;
        xfer(1'b0, 4, 1, 0, 1'b1, 1'b1, 1'b0);
        xfer(1'b0, 4, 1, 0, 1'b0, 1'b1, 1'b0);
        check("classic_rd", 64'(t_rd[0]), 64'h0000_0000_DEAD_BEEF);

        // three wait states
        t_dat[0] = 32'h00C0FFEE;
        xfer(1'b1, 0, 1, 0, 1'b1, 1'b1, 1'b0);
        xfer(1'b1, 0, 1, 0, 1'b0, 1'b1, 1'b0);
        check("ws3_rd", 64'(t_rd[0]), 64'h00C0FFEE);

        // linear burst write then read at byte 0x20
        for (int i = 0; i < 4; i++) t_dat[i] = 32'(i + 1);
        xfer(1'b0, 8, 4, 0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 8, 4, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("lin_rd", 64'(t_rd[i]), 64'(i + 1));

        // wrap4 from word 6 over words 4..7 = A..D
        for (int i = 0; i < 4; i++) t_dat[i] = 32'hA + 32'(i);
        xfer(1'b0, 4, 4, 0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 6, 4, 1, 1'b0, 1'b0, 1'b0);
        exp_w[0] = 32'hC; exp_w[1] = 32'hD; exp_w[2] = 32'hA; exp_w[3] = 32'hB;
        for (int i = 0; i < 4; i++) check("wrap4_rd", 64'(t_rd[i]), 64'(exp_w[i]));

        // byte-lane write
        t_dat[0] = 32'h11223344; t_sel[0] = 4'hF;
        xfer(1'b0, 12, 1, 0, 1'b1, 1'b1, 1'b0);
        t_dat[0] = 32'h00AA0000; t_sel[0] = 4'b0100;
        xfer(1'b0, 12, 1, 0, 1'b1, 1'b1, 1'b0);
        t_sel[0] = 4'hF;
        xfer(1'b0, 12, 1, 0, 1'b0, 1'b1, 1'b0);
        check("byte_rd", 64'(t_rd[0]), 64'h11AA3344);

        // stb dropped after two burst beats, then fresh access with wait states
        for (int i = 0; i < 4; i++) t_dat[i] = 32'h5000 + 32'(i);
        xfer(1'b1, 16, 4, 0, 1'b1, 1'b0, 1'b0);
        xfer(1'b1, 16, 2, 0, 1'b0, 1'b0, 1'b1);
        xfer(1'b1, 18, 1, 0, 1'b0, 1'b1, 1'b0);
        check("restart_rd", 64'(t_rd[0]), 64'h5002);

        // word 4096: error with range check, alias of word 0 without
        t_dat[0] = 32'h5A5A0000;
        xfer(1'b0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
        xfer(1'b0, 4096, 1, 0, 1'b0, 1'b1, 1'b0);
        check("range_err_flag", 64'(t_err), 64'(c_RC));
        check("range_dat", 64'(t_rd[0]), c_RC ? 64'd0 : 64'h5A5A0000);
        t_dat[0] = 32'h77; t_dat[1] = 32'h78;
        xfer(1'b0, 4094, 2, 0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 4094, 4, 0, 1'b0, 1'b0, 1'b0);
        check("cross_err_flag", 64'(t_err), 64'(c_RC));

        // random traffic
        for (int k = 0; k < 40; k++) begin
            bt  = $urandom_range(0, 3);
            len = (bt == 1) ? 4 : (bt == 2) ? 8 : (bt == 3) ? 16 : 6;
            n   = $urandom_range(1, len);
            for (int i = 0; i < 16; i++) begin
                t_dat[i] = $urandom;
                t_sel[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
            end
            xfer(1'($urandom_range(0, 1)), $urandom_range(0, 63), n, bt,
                 1'($urandom_range(0, 1)), (n == 1) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        // asynchronous reset in the middle of a burst
        @(posedge clk); #1;
        r_dsel = 1'b0; r_cyc = 1'b1; r_stb = 1'b1; r_we = 1'b0;
        r_adr = 32'(8 * 4); r_cti = 3'b010; r_bte = 2'b00; r_sel = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_ack", 64'(w_ack), 64'd1);
        #2 r_rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 64'(w_ack0), 64'd0);
        check("rst_mid_dat", 64'(w_dat0), 64'd0);
        r_cyc = 1'b0; r_stb = 1'b0; r_cti = 3'b000;
        @(negedge clk);
        r_rst_n = 1'b1;
        t_sel[0] = 4'hF;
        xfer(1'b0, 8, 1, 0, 1'b0, 1'b1, 1'b0);
        check("post_rst_rd", 64'(t_rd[0]), 64'(mdl[0][8]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
